fe_fetch_pc: RTL and testbench

Program counter register and instruction-fetch sequencer for the fetch stage. It consumes `program_counter_new` from the next-PC selection mux, holds the architectural PC, and derives `program_counter_plus_4`, which it feeds back to that mux. It fetches each instruction from instruction memory over a req/gnt/rvalid handshake and presents it to decode with a valid flag. It advances only when the core signals that the current instruction has retired.

---
 rtl/fe_pkg.sv | 11 +
 rtl/fe_fetch_pc.sv | 71 +++++++
 tb/tb_fe_fetch_pc.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fe_pkg.sv
// fe_pkg: shared types and defaults for the fetch-stage PC sequencer (TRAP state with FE_MISALIGN_TRAP_EN).
package fe_pkg;
  typedef logic [31:0] RV32I_OPERAND_t;
  localparam RV32I_OPERAND_t FE_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] FE_NOP_INSTR = 32'h0000_0013;
`ifdef FE_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {FE_IDLE, FE_REQ, FE_WAIT, FE_VALID, FE_TRAP} fe_fetch_state_t;
`else
  typedef enum logic [2:0] {FE_IDLE, FE_REQ, FE_WAIT, FE_VALID} fe_fetch_state_t;
`endif
endpackage

// File: rtl/fe_fetch_pc.sv
// fe_fetch_pc: PC register and req/gnt/rvalid instruction-fetch sequencer.
// Define FE_MISALIGN_TRAP_EN for a sticky trap on misaligned advance targets.
module fe_fetch_pc
  import fe_pkg::*;
#(
  parameter RV32I_OPERAND_t RESET_PC = FE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FE_NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  RV32I_OPERAND_t program_counter_new,
  input  logic           pc_advance,
  output logic           imem_req,
  output RV32I_OPERAND_t imem_addr,
  input  logic           imem_gnt,
  input  logic           imem_rvalid,
  input  logic [31:0]    imem_rdata,
  output RV32I_OPERAND_t program_counter,
  output RV32I_OPERAND_t program_counter_plus_4,
  output logic [31:0]    instr,
  output logic           instr_valid
`ifdef FE_MISALIGN_TRAP_EN
  ,
  output logic           misalign_trap
`endif
);
  fe_fetch_state_t r_state, w_next;
  RV32I_OPERAND_t r_pc;
  logic [31:0] r_instr;
  logic w_adv, w_load, w_capture;
  assign w_adv = (r_state == FE_VALID) && pc_advance;
`ifdef FE_MISALIGN_TRAP_EN
  assign w_load = w_adv && (program_counter_new[1:0] == 2'b00);
  assign misalign_trap = (r_state == FE_TRAP);
`else
  assign w_load = w_adv;
`endif
  assign w_capture = imem_rvalid && ((r_state == FE_WAIT) || ((r_state == FE_REQ) && imem_gnt));
  always_comb begin
    w_next = r_state;
    case (r_state)
      FE_IDLE:  w_next = FE_REQ;
      FE_REQ:   w_next = imem_gnt ? (imem_rvalid ? FE_VALID : FE_WAIT) : FE_REQ;
      FE_WAIT:  w_next = imem_rvalid ? FE_VALID : FE_WAIT;
`ifdef FE_MISALIGN_TRAP_EN
      FE_VALID: w_next = w_adv ? (w_load ? FE_REQ : FE_TRAP) : FE_VALID;
`else
      FE_VALID: w_next = w_adv ? FE_REQ : FE_VALID;
`endif
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FE_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_next;
      if (w_load) r_pc <= program_counter_new & ~32'h3;
      if (w_capture) r_instr <= imem_rdata;
      else if (w_adv) r_instr <= NOP_INSTR;
    end
  end
  assign imem_req = (r_state == FE_REQ);
  assign imem_addr = r_pc;
  assign program_counter = r_pc;
  assign program_counter_plus_4 = r_pc + 32'd4;
  assign instr = r_instr;
  assign instr_valid = (r_state == FE_VALID);
endmodule

// File: tb/tb_fe_fetch_pc.sv
// tb_fe_fetch_pc: directed self-checking bench with an expected-instruction scoreboard.
module tb_fe_fetch_pc;
  import fe_pkg::*;
  logic clk = 0, rst_n = 0, pc_advance = 0, imem_gnt = 0, imem_rvalid = 0;
  RV32I_OPERAND_t program_counter_new = '0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, instr_valid;
  RV32I_OPERAND_t imem_addr, program_counter, program_counter_plus_4;
  logic [31:0] instr;
  int total = 0, bad = 0;
  logic [31:0] sb[$];
`ifdef FE_MISALIGN_TRAP_EN
  logic misalign_trap;
`endif
  fe_fetch_pc dut (
    .clk(clk), .rst_n(rst_n), .program_counter_new(program_counter_new), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .program_counter(program_counter),
    .program_counter_plus_4(program_counter_plus_4), .instr(instr), .instr_valid(instr_valid)
`ifdef FE_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] data, input int gnt_delay, input bit same);
    logic [31:0] pc0, e;
    pc0 = program_counter;
    for (int i = 0; i < gnt_delay; i++) begin
      pc_advance = i[0];
      program_counter_new = 32'hDEAD_0000;
      step();
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, pc0);
    end
    pc_advance = 0;
    imem_gnt = 1;
    imem_rvalid = same;
    imem_rdata = data;
    sb.push_back(data);
    step();
    imem_gnt = 0;
    if (!same) begin
      chk("wait_noreq", {31'd0, imem_req}, 32'd0);
      chk("wait_novalid", {31'd0, instr_valid}, 32'd0);
      imem_rvalid = 1;
      step();
    end
    imem_rvalid = 0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hXXXX_XXXX;
    chk("instr", instr, e);
    step();
    chk("instr_hold", instr, e);
  endtask
  task automatic advance(input logic [31:0] npc, input logic [31:0] exp_pc);
    pc_advance = 1;
    program_counter_new = npc;
    step();
    pc_advance = 0;
    chk("adv_pc", program_counter, exp_pc);
    chk("adv_addr", imem_addr, exp_pc);
    chk("adv_plus4", program_counter_plus_4, exp_pc + 32'd4);
    chk("adv_req", {31'd0, imem_req}, 32'd1);
    chk("adv_novalid", {31'd0, instr_valid}, 32'd0);
    chk("adv_nop", instr, 32'h0000_0013);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) step();
    chk("rst_pc", program_counter, 32'h0040_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
`ifdef FE_MISALIGN_TRAP_EN
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
`endif
    rst_n = 1;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    chk("first_novalid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0000_0093, 0, 0);
    advance(32'h0040_0010, 32'h0040_0010);
    fetch(32'h0010_0113, 5, 0);
    advance(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("wrap_plus4", program_counter_plus_4, 32'h0000_0000);
    fetch(32'h0020_0193, 0, 1);
    advance(32'h0000_0000, 32'h0000_0000);
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    chk("rstw_wait", {31'd0, imem_req}, 32'd0);
    rst_n = 0;
    step();
    rst_n = 1;
    imem_rvalid = 1;
    imem_rdata = 32'hBAD0_0001;
    chk("rstw_idle_noreq", {31'd0, imem_req}, 32'd0);
    step();
    imem_rvalid = 0;
    chk("rstw_novalid", {31'd0, instr_valid}, 32'd0);
    chk("rstw_instr", instr, 32'h0000_0013);
    chk("rstw_addr", imem_addr, 32'h0040_0000);
    chk("rstw_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0030_0213, 1, 0);
    advance(32'h0040_0008, 32'h0040_0008);
    fetch(32'h0040_0293, 0, 0);
    pc_advance = 1;
    program_counter_new = 32'h0040_0006;
    step();
    pc_advance = 0;
`ifdef FE_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      chk("trap_flag", {31'd0, misalign_trap}, 32'd1);
      chk("trap_pc", program_counter, 32'h0040_0008);
      chk("trap_noreq", {31'd0, imem_req}, 32'd0);
      chk("trap_novalid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    rst_n = 0;
    step();
    rst_n = 1;
    chk("trap_cleared", {31'd0, misalign_trap}, 32'd0);
`else
    chk("mis_pc", program_counter, 32'h0040_0004);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0050_0313, 0, 0);
`endif
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
